multi_serial_accumulator: RTL and testbench

MULTI_SERIAL_ACCUMULATOR -- requirements
Module: multi_serial_accumulator

---
 rtl/serial_acc_pkg.sv | 14 +
 rtl/serial_digit_adder.sv | 27 ++
 rtl/multi_serial_accumulator.sv | 152 +++++++++++++++
 tb/tb_multi_serial_accumulator.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_acc_pkg.sv
// Shared types and default sizing for the multi-channel digit-serial accumulator.
package serial_acc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int N_DEF  = 16;
   localparam int D_DEF  = 4;
   localparam int CH_DEF = 4;

endpackage

// File: rtl/serial_digit_adder.sv
// D-bit ripple adder for one digit; also exposes the carry into the digit MSB
// so the caller can detect signed overflow on the most significant digit.
module serial_digit_adder #(
   parameter int D = 4
) (
   input  logic [D-1:0] a,
   input  logic [D-1:0] b,
   input  logic         cin,
   output logic [D-1:0] sum,
   output logic         cout,
   output logic         c_msb
);

   always_comb begin
      logic carry;
      carry = cin;
      sum   = '0;
      c_msb = cin;
      for (int i = 0; i < D; i++) begin
         if (i == D - 1) c_msb = carry;
         sum[i] = a[i] ^ b[i] ^ carry;
         carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      cout = carry;
   end

endmodule

// File: rtl/multi_serial_accumulator.sv
// CH-channel accumulator that adds/subtracts one N-bit operand D bits per clock.
// Define SERIAL_ACC_SAT_EN to saturate on signed overflow instead of wrapping.
module multi_serial_accumulator
   import serial_acc_pkg::*;
#(
   parameter  int N  = N_DEF,
   parameter  int D  = D_DEF,
   parameter  int CH = CH_DEF,
   localparam int CW = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [CW-1:0] in_ch,
   input  logic [N-1:0]  in_data,
   input  logic          in_sub,
   input  logic          clear_all,
   output logic          out_valid,
   output logic [CW-1:0] out_ch,
   output logic [N-1:0]  out_sum,
   output logic          out_ovf,
   output logic          out_err
);

   localparam int DIG  = N / D;
   localparam int CNTW = (DIG > 1) ? $clog2(DIG) : 1;
   localparam logic [CW:0] CH_L = (CW + 1)'(CH);

   if (N % D != 0) begin : g_bad_digit
      $error("multi_serial_accumulator: N must be a multiple of D");
   end

   state_t            state, state_nxt;
   logic [CNTW-1:0]   cnt;
   logic              carry;
   logic [N-1:0]      acc [CH];
   logic [N-1:0]      acc_sh, op_sh, res_sh;
   logic [CW-1:0]     ch_q;
   logic              err_q;
   logic              accept, last, bad_ch, ovf;
   logic [D-1:0]      dsum;
   logic              dcout, dmsb;
   logic signed [N-1:0] wrapped, stored;

`ifdef SERIAL_ACC_SAT_EN
   function automatic logic signed [N-1:0] saturate(input logic signed [N-1:0] value,
                                                    input logic overflow,
                                                    input logic msb_carry);
      if (!overflow) return value;
      // Carry out of the MSB on overflow means both operands were negative.
      if (msb_carry) return {1'b1, {(N-1){1'b0}}};
      return {1'b0, {(N-1){1'b1}}};
   endfunction
`endif

   assign accept  = in_valid && in_ready;
   assign last    = (cnt == CNTW'(DIG - 1));
   assign bad_ch  = ({1'b0, in_ch} >= CH_L);
   assign wrapped = N'({dsum, res_sh} >> D);
   assign ovf     = dmsb ^ dcout;

`ifdef SERIAL_ACC_SAT_EN
   assign stored = saturate(wrapped, ovf, dcout);
`else
   assign stored = wrapped;
`endif

   serial_digit_adder #(.D(D)) u_digit (
      .a     (acc_sh[D-1:0]),
      .b     (op_sh[D-1:0]),
      .cin   (carry),
      .sum   (dsum),
      .cout  (dcout),
      .c_msb (dmsb)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = !clear_all;
            if (in_valid && !clear_all) state_nxt = ADD;
         end
         ADD: begin
            if (clear_all) state_nxt = IDLE;
            else if (last) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt     <= '0;
         carry   <= 1'b0;
         acc_sh  <= '0;
         op_sh   <= '0;
         res_sh  <= '0;
         ch_q    <= '0;
         err_q   <= 1'b0;
         out_sum <= '0;
         out_ch  <= '0;
         out_ovf <= 1'b0;
         out_err <= 1'b0;
         for (int i = 0; i < CH; i++) acc[i] <= '0;
      end else begin
         if (accept) begin
            // Subtraction is the add of ~in_data with the +1 fed in as initial carry.
            ch_q   <= in_ch;
            err_q  <= bad_ch;
            acc_sh <= bad_ch ? '0 : acc[in_ch];
            op_sh  <= in_sub ? ~in_data : in_data;
            carry  <= in_sub;
            cnt    <= '0;
         end else if (state == ADD && !clear_all) begin
            acc_sh <= acc_sh >> D;
            op_sh  <= op_sh >> D;
            res_sh <= wrapped;
            carry  <= dcout;
            cnt    <= cnt + 1'b1;
            if (last) begin
               out_ch  <= ch_q;
               out_err <= err_q;
               if (err_q) begin
                  out_sum <= '0;
                  out_ovf <= 1'b0;
               end else begin
                  out_sum    <= stored;
                  out_ovf    <= ovf;
                  acc[ch_q]  <= stored;
               end
            end
         end
         if (clear_all) begin
            for (int i = 0; i < CH; i++) acc[i] <= '0;
         end
      end
   end

endmodule

// File: tb/tb_multi_serial_accumulator.sv
// Directed bench for multi_serial_accumulator: a CH=4 instance and a CH=3 instance
// share clock/reset and stimulus; sel chooses which one the steps talk to.
module tb_multi_serial_accumulator;

   logic        clk = 1'b0;
   logic        reset;
   logic        iv, sel, clear_all, in_sub;
   logic [1:0]  in_ch;
   logic [15:0] in_data;

   logic        rdy_a, vld_a, ovf_a, err_a;
   logic [1:0]  ch_a;
   logic [15:0] sum_a;
   logic        rdy_b, vld_b, ovf_b, err_b;
   logic [1:0]  ch_b;
   logic [15:0] sum_b;

   logic        in_ready, out_valid, out_ovf, out_err;
   logic [1:0]  out_ch;
   logic [15:0] out_sum;

   int tests = 0;
   int fails = 0;

`ifdef SERIAL_ACC_SAT_EN
   localparam logic [15:0] POS_OVF = 16'h7FFF;
   localparam logic [15:0] NEG_OVF = 16'h8000;
`else
   localparam logic [15:0] POS_OVF = 16'h8000;
   localparam logic [15:0] NEG_OVF = 16'h7FFF;
`endif

   always #5 clk = ~clk;

   assign in_ready  = sel ? rdy_b : rdy_a;
   assign out_valid = sel ? vld_b : vld_a;
   assign out_ch    = sel ? ch_b  : ch_a;
   assign out_sum   = sel ? sum_b : sum_a;
   assign out_ovf   = sel ? ovf_b : ovf_a;
   assign out_err   = sel ? err_b : err_a;

   multi_serial_accumulator #(.N(16), .D(4), .CH(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (iv & ~sel),
      .in_ready  (rdy_a),
      .in_ch     (in_ch),
      .in_data   (in_data),
      .in_sub    (in_sub),
      .clear_all (clear_all),
      .out_valid (vld_a),
      .out_ch    (ch_a),
      .out_sum   (sum_a),
      .out_ovf   (ovf_a),
      .out_err   (err_a)
   );

   multi_serial_accumulator #(.N(16), .D(4), .CH(3)) dut3 (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (iv & sel),
      .in_ready  (rdy_b),
      .in_ch     (in_ch),
      .in_data   (in_data),
      .in_sub    (in_sub),
      .clear_all (clear_all),
      .out_valid (vld_b),
      .out_ch    (ch_b),
      .out_sum   (sum_b),
      .out_ovf   (ovf_b),
      .out_err   (err_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [1:0] ch, input logic [15:0] data, input logic sub);
      int n = 0;
      while (in_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("ready_before_accept", in_ready, 1);
      in_ch   = ch;
      in_data = data;
      in_sub  = sub;
      iv      = 1'b1;
      @(posedge clk);
      #1;
      iv = 1'b0;
   endtask

   task automatic run(input string tag, input logic [1:0] ch, input logic [15:0] data,
                      input logic sub, input logic [15:0] exp_sum, input logic exp_ovf,
                      input logic exp_err);
      int lat  = 0;
      int busy = 0;
      send(ch, data, sub);
      do begin
         @(negedge clk);
         lat++;
         if (in_ready !== 1'b1) busy++;
      end while (out_valid !== 1'b1 && lat < 20);
      chk({tag, "_latency"}, lat, 5);
      chk({tag, "_ready_low"}, busy, 5);
      chk({tag, "_sum"}, out_sum, exp_sum);
      chk({tag, "_ch"}, out_ch, ch);
      chk({tag, "_ovf"}, out_ovf, exp_ovf);
      chk({tag, "_err"}, out_err, exp_err);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout observed=hang expected=finish");
      $fatal(1, "timeout");
   end

   initial begin
      int seen;
      iv = 1'b0; sel = 1'b0; clear_all = 1'b0;
      in_ch = '0; in_data = '0; in_sub = 1'b0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_valid", out_valid, 0);
      chk("rst_sum", out_sum, 0);
      chk("rst_ch", out_ch, 0);
      chk("rst_ovf", out_ovf, 0);
      chk("rst_err", out_err, 0);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_ready", in_ready, 1);

      // Basic accumulation on one channel.
      run("add5", 2'd1, 16'h0005, 1'b0, 16'h0005, 1'b0, 1'b0);
      run("add3", 2'd1, 16'h0003, 1'b0, 16'h0008, 1'b0, 1'b0);
      @(negedge clk);
      chk("post_done_ready", in_ready, 1);
      chk("post_done_valid", out_valid, 0);

      // Subtract through zero, then confirm other channels untouched.
      run("ch2_load", 2'd2, 16'h0010, 1'b0, 16'h0010, 1'b0, 1'b0);
      run("ch2_sub",  2'd2, 16'h0011, 1'b1, 16'hFFFF, 1'b0, 1'b0);
      run("ch0_keep", 2'd0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
      run("ch1_keep", 2'd1, 16'h0000, 1'b0, 16'h0008, 1'b0, 1'b0);
      run("ch3_keep", 2'd3, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);

      // Signed overflow in both directions.
      run("ch0_max",  2'd0, 16'h7FFF, 1'b0, 16'h7FFF, 1'b0, 1'b0);
      run("pos_ovf",  2'd0, 16'h0001, 1'b0, POS_OVF,  1'b1, 1'b0);
      run("pos_kept", 2'd0, 16'h0000, 1'b0, POS_OVF,  1'b0, 1'b0);
      run("ch3_min",  2'd3, 16'h8000, 1'b0, 16'h8000, 1'b0, 1'b0);
      run("neg_ovf",  2'd3, 16'h0001, 1'b1, NEG_OVF,  1'b1, 1'b0);
      run("neg_kept", 2'd3, 16'h0000, 1'b0, NEG_OVF,  1'b0, 1'b0);

      // clear_all on the second ADD cycle aborts the operation.
      send(2'd1, 16'h0005, 1'b0);
      @(negedge clk);
      @(negedge clk);
      clear_all = 1'b1;
      #1;
      chk("clr_ready_low", in_ready, 0);
      @(posedge clk);
      #1;
      clear_all = 1'b0;
      @(negedge clk);
      chk("clr_ready_next", in_ready, 1);
      chk("clr_valid_next", out_valid, 0);
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (out_valid === 1'b1) seen++;
      end
      chk("clr_no_valid", seen, 0);
      run("clr_ch0", 2'd0, 16'h0001, 1'b0, 16'h0001, 1'b0, 1'b0);
      run("clr_ch2", 2'd2, 16'h0001, 1'b0, 16'h0001, 1'b0, 1'b0);
      run("clr_ch1", 2'd1, 16'h0001, 1'b0, 16'h0001, 1'b0, 1'b0);

      // Reset in the middle of ADD discards the operation.
      send(2'd0, 16'h1234, 1'b0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midrst_valid", out_valid, 0);
      chk("midrst_sum", out_sum, 0);
      chk("midrst_ch", out_ch, 0);
      chk("midrst_ovf", out_ovf, 0);
      chk("midrst_err", out_err, 0);
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid === 1'b1) seen++;
      end
      chk("midrst_no_valid", seen, 0);
      chk("midrst_ready", in_ready, 1);
      run("midrst_ch0", 2'd0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
      run("midrst_ch1", 2'd1, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);

      // Three-channel instance: out-of-range channel reports an error only.
      sel = 1'b1;
      @(negedge clk);
      run("c3_ch0",  2'd0, 16'h0011, 1'b0, 16'h0011, 1'b0, 1'b0);
      run("c3_ch2",  2'd2, 16'h0022, 1'b0, 16'h0022, 1'b0, 1'b0);
      run("c3_bad",  2'd3, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b1);
      run("c3_k0",   2'd0, 16'h0000, 1'b0, 16'h0011, 1'b0, 1'b0);
      run("c3_k1",   2'd1, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
      run("c3_k2",   2'd2, 16'h0000, 1'b0, 16'h0022, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
